// File: rtl/jt12_pg_pkg.sv
// Shared constants, frequency entry type and slot-to-entry mapping for the
// JT12 phase-generator frequency scheduler.
package jt12_pg_pkg;

  localparam int unsigned NchDef = 6;
  localparam int unsigned NopDef = 4;

  localparam logic [7:0] AddrA0 = 8'hA0;
  localparam logic [7:0] AddrA4 = 8'hA4;
  localparam logic [7:0] AddrA8 = 8'hA8;
  localparam logic [7:0] AddrAc = 8'hAC;

  // Entries 0-5 are the normal channels, 6-8 the channel-3 special entries.
  localparam logic [3:0] SpecBase = 4'd6;

  typedef struct packed {
    logic [2:0]  block;
    logic [10:0] fnum;
  } freq_t;

  typedef logic [3:0] entry_t;

  // True for the three usable addresses of a 4-address group (xx0..xx2).
  function automatic logic in_group(logic [7:0] addr, logic [7:0] base);
    return (addr[7:2] == base[7:2]) && (addr[1:0] != 2'd3);
  endfunction

  // op0/op1/op2 of channel 2 use special entries A9/AA/A8; op3 stays normal.
  function automatic entry_t slot_entry(logic [2:0] ch, logic [1:0] op, logic ch3_mode);
    entry_t e;
    e = entry_t'(ch);
    if (ch3_mode && (ch == 3'd2) && (op != 2'd3)) begin
      case (op)
        2'd0:    e = SpecBase + 4'd1;
        2'd1:    e = SpecBase + 4'd2;
        default: e = SpecBase;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/jt12_pg_sched_if.sv
// Register-write bus and slot output bundle of the phase-generator scheduler.
interface jt12_pg_sched_if;
  logic        clk_en;
  logic        wr;
  logic        part;
  logic [7:0]  addr;
  logic [7:0]  din;
  logic        ch3_mode;
  logic [2:0]  block;
  logic [10:0] fnum;
  logic [2:0]  ch;
  logic [1:0]  op;
  logic        zero;

  modport master (
    output clk_en, wr, part, addr, din, ch3_mode,
    input  block, fnum, ch, op, zero
  );

  modport slave (
    input  clk_en, wr, part, addr, din, ch3_mode,
    output block, fnum, ch, op, zero
  );
endinterface

// File: rtl/jt12_pg_freq_rf.sv
// Frequency register file: six channel entries, high-byte latches and, with
// JT12_CH3_SPECIAL_EN defined, the three channel-3 special entries.
module jt12_pg_freq_rf
  import jt12_pg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic       part_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] din_i,
  input  entry_t     rd_idx_i,
  output freq_t      rd_o
);

  freq_t      norm_q [NchDef];
  logic [5:0] lat_q;
  logic [2:0] wr_idx;

  assign wr_idx = 3'(addr_i[1:0]) + (part_i ? 3'd3 : 3'd0);

  // Latch write and commit in one edge: the commit uses the previous latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NchDef); i++) norm_q[i] <= '0;
      lat_q <= '0;
    end else if (wr_i) begin
      if (in_group(addr_i, AddrA4)) lat_q <= din_i[5:0];
      if (in_group(addr_i, AddrA0)) norm_q[wr_idx] <= {lat_q, din_i};
    end
  end

`ifdef JT12_CH3_SPECIAL_EN
  freq_t      spec_q [3];
  logic [5:0] lat_s_q;
  logic [3:0] spec_rd;

  assign spec_rd = rd_idx_i - SpecBase;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) spec_q[i] <= '0;
      lat_s_q <= '0;
    end else if (wr_i && !part_i) begin
      if (in_group(addr_i, AddrAc)) lat_s_q <= din_i[5:0];
      if (in_group(addr_i, AddrA8)) spec_q[addr_i[1:0]] <= {lat_s_q, din_i};
    end
  end

  always_comb begin
    rd_o = '0;
    if (rd_idx_i < SpecBase) rd_o = norm_q[rd_idx_i[2:0]];
    else if (spec_rd < 4'd3) rd_o = spec_q[spec_rd[1:0]];
  end
`else
  always_comb begin
    rd_o = '0;
    if (rd_idx_i < SpecBase) rd_o = norm_q[rd_idx_i[2:0]];
  end
`endif

endmodule

// File: rtl/jt12_pg_sched.sv
// JT12 frequency scheduler: walks 24 slots (ch inner, op outer) on clk_en and
// registers block/fnum for each. Macro JT12_CH3_SPECIAL_EN enables ch3 mode.
module jt12_pg_sched
  import jt12_pg_pkg::*;
#(
  parameter int unsigned NCH = NchDef,
  parameter int unsigned NOP = NopDef
) (
  input logic             clk,
  input logic             rst,
  jt12_pg_sched_if.slave  bus_io
);

  logic [2:0] ch_q, ch_d, out_ch_q, out_ch_d;
  logic [1:0] op_q, op_d, out_op_q, out_op_d;
  freq_t      out_freq_q, out_freq_d;
  logic       zero_q, zero_d;
  logic       ch3_eff;
  freq_t      slot_freq;

`ifdef JT12_CH3_SPECIAL_EN
  assign ch3_eff = bus_io.ch3_mode;
`else
  logic unused_ch3_mode;
  assign unused_ch3_mode = bus_io.ch3_mode;
  assign ch3_eff         = 1'b0;
`endif

  jt12_pg_freq_rf u_rf (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (bus_io.wr),
    .part_i   (bus_io.part),
    .addr_i   (bus_io.addr),
    .din_i    (bus_io.din),
    .rd_idx_i (slot_entry(ch_q, op_q, ch3_eff)),
    .rd_o     (slot_freq)
  );

  always_comb begin
    ch_d       = ch_q;
    op_d       = op_q;
    out_ch_d   = out_ch_q;
    out_op_d   = out_op_q;
    out_freq_d = out_freq_q;
    zero_d     = zero_q;
    if (bus_io.clk_en) begin
      out_ch_d   = ch_q;
      out_op_d   = op_q;
      out_freq_d = slot_freq;
      zero_d     = (ch_q == 3'd0) && (op_q == 2'd0);
      if (ch_q == 3'(NCH - 1)) begin
        ch_d = '0;
        op_d = (op_q == 2'(NOP - 1)) ? 2'd0 : op_q + 2'd1;
      end else begin
        ch_d = ch_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      op_q       <= '0;
      out_ch_q   <= '0;
      out_op_q   <= '0;
      out_freq_q <= '0;
      zero_q     <= 1'b1;
    end else begin
      ch_q       <= ch_d;
      op_q       <= op_d;
      out_ch_q   <= out_ch_d;
      out_op_q   <= out_op_d;
      out_freq_q <= out_freq_d;
      zero_q     <= zero_d;
    end
  end

  assign bus_io.block = out_freq_q.block;
  assign bus_io.fnum  = out_freq_q.fnum;
  assign bus_io.ch    = out_ch_q;
  assign bus_io.op    = out_op_q;
  assign bus_io.zero  = zero_q;

endmodule

// File: tb/tb_jt12_pg_sched.sv
// Bench for jt12_pg_sched: slot/frequency model checked every cycle, plus
// hand-computed literal checks on the directed scenarios.
module tb_jt12_pg_sched;

  logic clk = 1'b0;
  logic rst;
  jt12_pg_sched_if bus ();

  jt12_pg_sched dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model state: entries hold {block, fnum} as 14-bit integers.
  int m_norm [6];
  int m_spec [3];
  int m_lat_n, m_lat_s, m_slot;
  int e_blk, e_fn, e_ch, e_op, e_zero;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int c, o, f, a;
    if (rst) begin
      for (int i = 0; i < 6; i++) m_norm[i] = 0;
      for (int i = 0; i < 3; i++) m_spec[i] = 0;
      m_lat_n = 0; m_lat_s = 0; m_slot = 0;
      e_blk = 0; e_fn = 0; e_ch = 0; e_op = 0; e_zero = 1;
    end else begin
      if (bus.clk_en) begin
        c = m_slot % 6;
        o = m_slot / 6;
        f = m_norm[c];
`ifdef JT12_CH3_SPECIAL_EN
        if (bus.ch3_mode && c == 2 && o < 3) f = m_spec[(o + 1) % 3];
`endif
        e_blk  = f >> 11;
        e_fn   = f & 'h7FF;
        e_ch   = c;
        e_op   = o;
        e_zero = (m_slot == 0) ? 1 : 0;
        m_slot = (m_slot + 1) % 24;
      end
      if (bus.wr) begin
        a = int'(bus.addr);
        if (a >= 'hA0 && a <= 'hA2)
          m_norm[int'(bus.part) * 3 + a - 'hA0] = (m_lat_n << 8) | int'(bus.din);
        else if (a >= 'hA4 && a <= 'hA6)
          m_lat_n = int'(bus.din) & 'h3F;
`ifdef JT12_CH3_SPECIAL_EN
        else if (!bus.part && a >= 'hA8 && a <= 'hAA)
          m_spec[a - 'hA8] = (m_lat_s << 8) | int'(bus.din);
        else if (!bus.part && a >= 'hAC && a <= 'hAE)
          m_lat_s = int'(bus.din) & 'h3F;
`endif
      end
    end
  endtask

  // One clock: advance model on the edge, compare the DUT just after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_block", int'(bus.block), e_blk);
    chk("model_fnum",  int'(bus.fnum),  e_fn);
    chk("model_ch",    int'(bus.ch),    e_ch);
    chk("model_op",    int'(bus.op),    e_op);
    chk("model_zero",  int'(bus.zero),  e_zero);
  endtask

  task automatic wr_reg(input logic p, input logic [7:0] a, input logic [7:0] d);
    bus.wr = 1'b1; bus.part = p; bus.addr = a; bus.din = d;
    tick();
    bus.wr = 1'b0;
  endtask

  int zc;
  int exp_fn2 [4];
  int exp_bl2 [4];

  initial begin
    rst = 1'b1;
    bus.clk_en = 1'b0; bus.wr = 1'b0; bus.part = 1'b0;
    bus.addr = 8'h00; bus.din = 8'h00; bus.ch3_mode = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_zero", int'(bus.zero), 1);
    chk("rst_fnum", int'(bus.fnum), 0);

    // Two full frames; wrap op3/ch5 -> op0/ch0.
    bus.clk_en = 1'b1;
    zc = 0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (bus.zero) zc++;
      if (k == 24) begin
        chk("wrap_ch5", int'(bus.ch), 5);
        chk("wrap_op3", int'(bus.op), 3);
      end
      if (k == 25) begin
        chk("wrap_ch0", int'(bus.ch), 0);
        chk("wrap_zero", int'(bus.zero), 1);
      end
    end
    chk("zero_count", zc, 2);

    // Part 1 channel 4: block 4, fnum 0x26A.
    bus.clk_en = 1'b0;
    wr_reg(1'b1, 8'hA5, 8'h22);
    wr_reg(1'b1, 8'hA1, 8'h6A);
    bus.clk_en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k % 6 == 5) begin
        chk("ch4_block", int'(bus.block), 4);
        chk("ch4_fnum",  int'(bus.fnum),  'h26A);
      end
    end

    // Latch reuse: ch0 and ch2 both from one high write.
    bus.clk_en = 1'b0;
    wr_reg(1'b0, 8'hA4, 8'h1C);
    wr_reg(1'b0, 8'hA0, 8'h11);
    wr_reg(1'b0, 8'hA2, 8'h33);
    wr_reg(1'b1, 8'hAC, 8'h3F);
    bus.clk_en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k % 6 == 1) begin
        chk("ch0_block", int'(bus.block), 3);
        chk("ch0_fnum",  int'(bus.fnum),  'h411);
      end
      if (k % 6 == 3) begin
        chk("ch2_block", int'(bus.block), 3);
        chk("ch2_fnum",  int'(bus.fnum),  'h433);
      end
    end

    // Channel-3 special entries (block 1) and normal ch2 = block 2, 0x400.
    bus.clk_en = 1'b0;
    wr_reg(1'b0, 8'hAD, 8'h09);
    wr_reg(1'b0, 8'hA9, 8'h00);
    wr_reg(1'b0, 8'hAD, 8'h0A);
    wr_reg(1'b0, 8'hAA, 8'h00);
    wr_reg(1'b0, 8'hAD, 8'h0B);
    wr_reg(1'b0, 8'hA8, 8'h00);
    wr_reg(1'b0, 8'hA6, 8'h14);
    wr_reg(1'b0, 8'hA2, 8'h00);
`ifdef JT12_CH3_SPECIAL_EN
    exp_fn2 = '{'h100, 'h200, 'h300, 'h400};
    exp_bl2 = '{1, 1, 1, 2};
`else
    exp_fn2 = '{'h400, 'h400, 'h400, 'h400};
    exp_bl2 = '{2, 2, 2, 2};
`endif
    bus.ch3_mode = 1'b1;
    bus.clk_en   = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k % 6 == 3) begin
        chk("ch3m_fnum",  int'(bus.fnum),  exp_fn2[(k - 1) / 6]);
        chk("ch3m_block", int'(bus.block), exp_bl2[(k - 1) / 6]);
      end
    end
    bus.ch3_mode = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k % 6 == 3) chk("ch2_norm_fnum", int'(bus.fnum), 'h400);
    end

    // Write ch0 on the edge that outputs ch0: old value shown, new later.
    bus.clk_en = 1'b1;
    wr_reg(1'b0, 8'hA0, 8'h55);
    chk("rw_old_fnum", int'(bus.fnum), 'h411);
    chk("rw_old_block", int'(bus.block), 3);
    bus.clk_en = 1'b0;
    tick();
    chk("hold_ch",   int'(bus.ch),   0);
    chk("hold_fnum", int'(bus.fnum), 'h411);
    for (int i = 0; i < 22; i++) begin
      bus.clk_en = (i % 2 == 1);
      tick();
      if (i == 11) begin
        chk("rw_new_op",    int'(bus.op),    1);
        chk("rw_new_ch",    int'(bus.ch),    0);
        chk("rw_new_fnum",  int'(bus.fnum),  'h455);
        chk("rw_new_block", int'(bus.block), 2);
      end
    end
    bus.clk_en = 1'b1;
    tick();
    chk("pre_rst_op", int'(bus.op), 2);

    // Reset mid-frame, overriding a simultaneous write and clk_en.
    rst = 1'b1;
    bus.wr = 1'b1; bus.part = 1'b0; bus.addr = 8'hA0; bus.din = 8'hFF;
    tick();
    rst = 1'b0; bus.wr = 1'b0;
    chk("mid_rst_zero", int'(bus.zero), 1);
    chk("mid_rst_op",   int'(bus.op),   0);
    chk("mid_rst_fnum", int'(bus.fnum), 0);
    tick();
    chk("restart_ch0_fnum", int'(bus.fnum), 0);
    chk("restart_zero",     int'(bus.zero), 1);
    tick();
    chk("restart_ch1", int'(bus.ch), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/jt12_pg_sched.md
JT12_PG_SCHED -- requirements
Module: jt12_pg_sched

Interface
REQ-001 Parameter NCH, default 6: number of FM channels sequenced, fixed at 6.
REQ-002 Parameter NOP, default 4: operators per channel, fixed at 4.
REQ-003 clk  in  1  system clock; the block has one clock, rising-edge only.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 clk_en  in  1  slot-advance enable; the sequencer and output stage move only when it is high.
REQ-006 wr  in  1  register write strobe, one cycle, sampled on every clk regardless of clk_en.
REQ-007 part  in  1  register bank: 0 selects channels 0-2, 1 selects channels 3-5.
REQ-008 addr  in  8  register address: A0-A2 fnum low, A4-A6 block/fnum high, A8-AA and AC-AE channel-3 special.
REQ-009 din  in  8  write data.
REQ-010 ch3_mode  in  1  channel-3 special (per-operator frequency) mode enable.
REQ-011 block  out  3  octave for the current slot, to the phase-increment calculator.
REQ-012 fnum  out  11  frequency number for the current slot.
REQ-013 ch  out  3  channel index of the current output slot, 0-5.
REQ-014 op  out  2  operator index of the current output slot, 0-3.
REQ-015 zero  out  1  high while the output slot is ch=0, op=0 (frame sync).

Function
REQ-016 The sequencer SHALL hold ch_cnt (0-5, inner) and op_cnt (0-3, outer), advancing only on clk_en; slot order is ch 0..5 for op0, then op1, op2, op3, giving 24 slots per frame.
REQ-017 ch_cnt SHALL wrap 5->0 and increment op_cnt; op_cnt SHALL wrap 3->0 on the same edge, so no slot is skipped or repeated.
REQ-018 Outputs SHALL be registered with one clk_en of latency: on the clk_en edge that advances the counters from slot S, block/fnum/ch/op/zero SHALL take the values of S.
REQ-019 With clk_en low, all outputs and counters SHALL hold.
REQ-020 A write to A4-A6 SHALL load the normal latch with {din[5:3] block, din[2:0] fnum[10:8]}; the frequency RAM is left unchanged.
REQ-021 A write to A0-A2 SHALL commit {latch block, latch fnum_hi, din} to channel part*3+(addr-A0) in the same edge.
REQ-022 Channel-3 special writes SHALL use a separate latch: AC-AE load it, A8-AA commit {special latch, din} to special entries 0-2.
REQ-023 Latches SHALL be shared by both parts and retain their value after a commit; repeated low writes reuse the last high write.
REQ-024 Writes with part=1 to A8-AE, and writes to any other address, SHALL be ignored.
REQ-025 A write to the entry being read in the same edge SHALL NOT affect that slot; the output shows the old value and later slots show the new value.
REQ-026 If ch3_mode=1 and the slot is ch=2, op0 SHALL use special entry 1 (A9), op1 entry 2 (AA), op2 entry 0 (A8), and op3 the normal channel-2 entry.
REQ-027 ch3_mode changes SHALL take effect at the next slot lookup, with no frame alignment.

Reset
REQ-028 On rst, all frequency entries, both latches, ch_cnt and op_cnt SHALL clear to 0, and block, fnum, ch and op SHALL clear to 0; zero SHALL be 1.
REQ-029 rst SHALL override wr and clk_en in the same cycle; a mid-frame reset restarts the sequencer at ch=0, op=0.

Configuration
REQ-030 With macro JT12_CH3_SPECIAL_EN defined, REQ-022, REQ-026 and REQ-027 SHALL apply.
REQ-031 Without JT12_CH3_SPECIAL_EN, the special latch and entries SHALL NOT exist, writes to A8-AE SHALL be ignored, and ch3_mode SHALL have no effect.

Structure
REQ-032 Package jt12_pg_pkg SHALL hold the address constants (A0, A4, A8, AC), the NCH and NOP constants, and typedef freq_t {block[2:0], fnum[10:0]}.
REQ-033 Sub-module jt12_pg_freq_rf SHALL hold the 6 normal entries, the 3 special entries and both latches; it has a synchronous write port and a combinational read port indexed by {ch, op, ch3_mode}.
REQ-034 The sequencer counters, slot-to-entry mapping and output register SHALL reside in jt12_pg_sched.

Verification
REQ-035 Hold clk_en=1 for 48 cycles after reset -> ch/op sweep 0..5 x 0..3 twice, zero high exactly on ch=0/op=0, including the op3/ch5 -> 0/0 wrap.
REQ-036 Write part=1 A5<=0x22 then A1<=0x6A -> channel 4 slots output block=4, fnum=0x26A; all other channels remain 0.
REQ-037 Write A4<=0x1C, A0<=0x11, then A2<=0x33 without a new high write -> ch0 output block=3, fnum=0x411; ch2 output block=3, fnum=0x433.
REQ-038 Set ch3_mode=1 with A9=0x100, AA=0x200, A8=0x300 (block 1) and A2=0x400 -> ch2 op0..op3 output fnum 0x100, 0x200, 0x300, 0x400; with ch3_mode=0 all four output 0x400.
REQ-039 Toggle clk_en 1/0 alternately, assert wr to A0 in the same edge as the ch0 output update, and assert rst at op=2 -> outputs hold while clk_en is low; the ch0 slot shows the old value and the next frame shows the new one; after rst the outputs are 0, zero=1 and the sequence restarts at 0/0.
